// File: rtl/mpu_wb_slave.sv
// Wishbone slave front-end for the MPU RAM window: one registered RAM request per access,
// acks paced to RAM_LAT, incrementing read bursts at one beat per clock.
module mpu_wb_slave #(
  parameter int ADR_W   = 15,
  parameter int RAM_LAT = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [2:0]       wb_cti_i,
  output logic             wb_ack_o,
  output logic [ADR_W-1:0] mem_adr_o,
  output logic [31:0]      mem_dat_o,
  output logic [3:0]       mem_sel_o,
  input  logic [31:0]      mem_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACK,
    S_RD_WAIT,
    S_RD_BURST,
    S_GAP
  } state_t;

  localparam logic [ADR_W-1:0] ADR_STEP = ADR_W'(4);
  localparam logic [1:0]       LAT_INIT = 2'(RAM_LAT);
  localparam logic [2:0]       CTI_INCR = 3'b010;

  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             burst_q, burst_d;
  logic             req;
  logic             unused_adr_bits;

  assign req             = wb_cyc_i & wb_stb_i;
  assign unused_adr_bits = ^{wb_adr_i[31:ADR_W], wb_adr_i[1:0]};

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = 4'b0000;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d = {wb_adr_i[ADR_W-1:2], 2'b00};
          dat_d = wb_dat_i;
          if (wb_we_i) begin
            sel_d   = wb_sel_i;
            ack_d   = 1'b1;
            state_d = S_WR_ACK;
          end else begin
            cnt_d   = LAT_INIT;
            burst_d = (wb_cti_i == CTI_INCR);
            state_d = S_RD_WAIT;
          end
        end
      end
      S_WR_ACK: state_d = req ? S_GAP : S_IDLE;
      S_RD_WAIT: begin
        // Single reads stay here for their ack cycle; bursts move on at the first ack.
        if (!req) begin
          state_d = S_IDLE;
        end else if (ack_q) begin
          state_d = S_GAP;
        end else begin
          if (burst_q) adr_d = adr_q + ADR_STEP;
          if (cnt_q == 2'd1) begin
            ack_d = 1'b1;
            if (burst_q) state_d = S_RD_BURST;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_RD_BURST: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          adr_d = adr_q + ADR_STEP;
          if (wb_cti_i == CTI_INCR) ack_d = 1'b1;
          else                      state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
    end
  end

  assign wb_ack_o  = ack_q & req;
  assign wb_dat_o  = mem_dat_i;
  assign mem_adr_o = adr_q;
  assign mem_dat_o = dat_q;
  assign mem_sel_o = sel_q;

endmodule

// File: tb/tb_mpu_wb_slave.sv
// Randomized Wishbone master plus synchronous RAM model around mpu_wb_slave,
// checked against a word-level shadow memory and cycle-count timing rules.
module tb_mpu_wb_slave;

  localparam int ADR_W   = 15;
  localparam int RAM_LAT = 1;
  localparam int WORDS   = 1 << (ADR_W - 2);

  logic             clk;
  logic             rst;
  logic [31:0]      wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]       wb_sel_i;
  logic             wb_cyc_i, wb_stb_i, wb_we_i;
  logic [2:0]       wb_cti_i;
  logic             wb_ack_o;
  logic [ADR_W-1:0] mem_adr_o;
  logic [31:0]      mem_dat_o;
  logic [3:0]       mem_sel_o;
  logic [31:0]      mem_dat_i;

  logic [31:0] ram     [WORDS];
  logic [31:0] exp_mem [WORDS];

  int vecs = 0;
  int errs = 0;

  mpu_wb_slave #(.ADR_W(ADR_W), .RAM_LAT(RAM_LAT)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_cti_i (wb_cti_i),
    .wb_ack_o (wb_ack_o),
    .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o),
    .mem_sel_o(mem_sel_o),
    .mem_dat_i(mem_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one clock read latency, byte-lane writes.
  initial begin : ram_model
    logic [ADR_W-1:0] cap_adr;
    logic [3:0]       cap_sel;
    logic [31:0]      cap_dat;
    for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
    ram[9] = 32'hCAFEF00D;
    mem_dat_i = '0;
    forever begin
      @(negedge clk);
      cap_adr = mem_adr_o;
      cap_sel = mem_sel_o;
      cap_dat = mem_dat_o;
      @(posedge clk);
      mem_dat_i = ram[cap_adr[ADR_W-1:2]];
      for (int b = 0; b < 4; b++)
        if (cap_sel[b]) ram[cap_adr[ADR_W-1:2]][8*b +: 8] = cap_dat[8*b +: 8];
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_cti_i = 3'b000;
  endtask

  function automatic logic [ADR_W-1:0] wadr(input logic [31:0] a);
    return {a[ADR_W-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] mk_adr(input int widx);
    logic [31:0] a;
    a = $urandom;
    a[ADR_W-1:2] = (ADR_W-2)'(widx);
    return a;
  endfunction

  task automatic shadow_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [ADR_W-1:0] w;
    w = wadr(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) exp_mem[w[ADR_W-1:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_cti_i = 3'b000;
    smp(); chk("wr_ack_before", 32'(wb_ack_o), 32'd0);
    nxt();
    smp();
    chk("wr_ack", 32'(wb_ack_o), 32'd1);
    chk("wr_sel", 32'(mem_sel_o), 32'(s));
    chk("wr_adr", 32'(mem_adr_o), 32'(wadr(a)));
    chk("wr_dat", mem_dat_o, d);
    shadow_write(a, d, s);
    nxt();
    drive_idle();
    smp();
    chk("wr_ack_after", 32'(wb_ack_o), 32'd0);
    chk("wr_sel_after", 32'(mem_sel_o), 32'd0);
    nxt();
  endtask

  task automatic do_read(input logic [31:0] a, input int n);
    logic [ADR_W-1:0] wa, ba;
    wa = wadr(a);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = a; wb_dat_i = $urandom; wb_sel_i = 4'($urandom);
    wb_cti_i = (n > 1) ? 3'b010 : 3'b000;
    smp(); chk("rd_ack_before", 32'(wb_ack_o), 32'd0);
    nxt();
    for (int c = 0; c < RAM_LAT; c++) begin
      smp();
      chk("rd_wait_ack", 32'(wb_ack_o), 32'd0);
      chk("rd_wait_sel", 32'(mem_sel_o), 32'd0);
      if (c == 0) chk("rd_req_adr", 32'(mem_adr_o), 32'(wa));
      nxt();
    end
    for (int k = 0; k < n; k++) begin
      ba = wa + ADR_W'(4 * k);
      wb_adr_i = 32'(ba);
      wb_cti_i = (n == 1) ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
      smp();
      chk("rd_beat_ack", 32'(wb_ack_o), 32'd1);
      chk("rd_beat_dat", wb_dat_o, exp_mem[ba[ADR_W-1:2]]);
      chk("rd_beat_sel", 32'(mem_sel_o), 32'd0);
      nxt();
    end
    drive_idle();
    smp(); chk("rd_ack_after", 32'(wb_ack_o), 32'd0);
    nxt();
  endtask

  initial begin : stim
    logic [31:0] a1, a2, d1, d2;
    logic [3:0]  s1, s2;
    int widx;
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    drive_idle();
    smp();
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_sel", 32'(mem_sel_o), 32'd0);
    chk("rst_adr", 32'(mem_adr_o), 32'd0);
    chk("rst_dat", mem_dat_o, 32'd0);
    nxt(); nxt();
    rst = 1'b0;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = ram[i];
    nxt();

    do_write(32'h0000_0010, 32'hDEADBEEF, 4'b0101);
    do_read(32'h0000_0024, 1);
    chk("rd_cafe", exp_mem[9], 32'hCAFEF00D);
    do_read(32'h0000_0010, 1);
    do_read(32'h0000_7FF8, 4);

    // Read aborted right after the request is sampled.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0000_0040; wb_cti_i = 3'b000;
    nxt();
    drive_idle();
    smp(); chk("abort_ack_n1", 32'(wb_ack_o), 32'd0);
    nxt();
    do_write(32'h0000_0044, 32'h1234_5678, 4'b1111);
    do_read(32'h0000_0044, 1);

    // Async reset in the middle of a burst.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0000_0100; wb_cti_i = 3'b010;
    nxt(); nxt();
    smp(); chk("rstb_beat0", 32'(wb_ack_o), 32'd1);
    nxt();
    smp(); chk("rstb_beat1", 32'(wb_ack_o), 32'd1);
    nxt();
    chk("rstb_beat2", 32'(wb_ack_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstb_ack", 32'(wb_ack_o), 32'd0);
    chk("rstb_sel", 32'(mem_sel_o), 32'd0);
    chk("rstb_adr", 32'(mem_adr_o), 32'd0);
    drive_idle();
    nxt(); nxt();
    rst = 1'b0;
    nxt();
    do_read(32'h0000_0104, 1);

    // Back-to-back writes with cyc/stb held high.
    a1 = mk_adr(20); d1 = $urandom; s1 = 4'b0011;
    a2 = mk_adr(21); d2 = $urandom; s2 = 4'b1100;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = a1; wb_dat_i = d1; wb_sel_i = s1; wb_cti_i = 3'b000;
    nxt();
    smp();
    chk("b2b_ack1", 32'(wb_ack_o), 32'd1);
    chk("b2b_sel1", 32'(mem_sel_o), 32'(s1));
    shadow_write(a1, d1, s1);
    nxt();
    wb_adr_i = a2; wb_dat_i = d2; wb_sel_i = s2;
    smp(); chk("b2b_gap_ack", 32'(wb_ack_o), 32'd0); chk("b2b_gap_sel", 32'(mem_sel_o), 32'd0);
    nxt();
    smp(); chk("b2b_idle_ack", 32'(wb_ack_o), 32'd0); chk("b2b_idle_sel", 32'(mem_sel_o), 32'd0);
    nxt();
    smp();
    chk("b2b_ack2", 32'(wb_ack_o), 32'd1);
    chk("b2b_sel2", 32'(mem_sel_o), 32'(s2));
    chk("b2b_dat2", mem_dat_o, d2);
    shadow_write(a2, d2, s2);
    nxt();
    drive_idle();
    smp(); chk("b2b_end_sel", 32'(mem_sel_o), 32'd0);
    nxt();
    do_read(a1, 2);

    // Random mix over a small pool of words at both ends of the window.
    for (int t = 0; t < 60; t++) begin
      widx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : WORDS - 1 - $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0)
        do_write(mk_adr(widx), $urandom, 4'($urandom));
      else
        do_read(mk_adr(widx), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
